// File: rtl/time_entry_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : time_entry_ctrl
// Function : keypad HH[:MM[:SS]] entry with 24-hour digit validation,
//            backspace, cancel, alarm slot select and scan-mux display.
//            Optional cursor blink: define TIME_ENTRY_BLINK_EN.
// Revision : 1.0
// =====================================================================
module time_entry_ctrl #(
    parameter int DIGITS    = 6,
    parameter int ALARMS    = 2,
    parameter int SCAN_W    = 3,
    parameter int BLINK_DIV = 25000000,
    localparam int AW       = (ALARMS > 1) ? $clog2(ALARMS) : 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic [3:0]            key_code,
    input  logic                  key_valid,
    input  logic [SCAN_W-1:0]     rr,
    output logic [4*DIGITS-1:0]   itime,
    output logic                  itime_valid,
    output logic                  set,
    output logic [AW-1:0]         alarm_slot,
    output logic                  in,
    output logic                  err,
    output logic [4:0]            digit_holder
);

    localparam int            CW         = $clog2(DIGITS + 1);
    localparam int            BW         = 4 * DIGITS;
    localparam logic [CW-1:0] C_CUR_FULL = CW'(DIGITS);
    localparam logic [AW-1:0] C_SLOT_MAX = AW'(ALARMS - 1);
    localparam logic [4:0]    C_BLANK    = 5'b10000;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ENTRY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cur_q, cur_d;
    logic            set_q, set_d;
    logic [AW-1:0]   slot_q, slot_d;
    logic            in_q, in_d;
    logic            err_q, err_d;
    logic [BW-1:0]   itime_q, itime_d;
    logic            ival_q, ival_d;
    logic [4:0]      dh_q, dh_d;
    logic [3:0]      dig_lim;
    logic            accept;

    // Largest legal digit at the cursor; buffer digit 0 sits in the top nibble.
    always_comb begin
        if (cur_q[0] == 1'b0)
            dig_lim = (cur_q == '0) ? 4'd2 : 4'd5;
        else
            dig_lim = (cur_q == CW'(1) && buf_q[BW-1 -: 4] == 4'd2) ? 4'd3 : 4'd9;
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cur_d   = cur_q;
        set_d   = set_q;
        slot_d  = slot_q;
        in_d    = in_q;
        itime_d = itime_q;
        err_d   = 1'b0;
        ival_d  = 1'b0;
        accept  = 1'b0;
        if (key_valid) begin
            if (state_q == S_IDLE) begin
                if (key_code == 4'ha || key_code == 4'hb) begin
                    state_d = S_ENTRY;
                    set_d   = (key_code == 4'hb);
                    if (key_code == 4'hb)
                        slot_d = '0;
                    buf_d   = '0;
                    cur_d   = '0;
                    in_d    = 1'b1;
                    accept  = 1'b1;
                end
            end else if (key_code <= 4'h9) begin
                if (cur_q == C_CUR_FULL || key_code > dig_lim) begin
                    err_d = 1'b1;
                end else begin
                    buf_d[4*(DIGITS-1-int'(cur_q)) +: 4] = key_code;
                    cur_d  = cur_q + 1'b1;
                    accept = 1'b1;
                end
            end else begin
                case (key_code)
                    4'hc: begin
                        if (cur_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            buf_d[4*(DIGITS-int'(cur_q)) +: 4] = 4'h0;
                            cur_d  = cur_q - 1'b1;
                            accept = 1'b1;
                        end
                    end
                    4'hd: begin
                        state_d = S_IDLE;
                        in_d    = 1'b0;
                        accept  = 1'b1;
                    end
                    4'he: begin
                        if (cur_q == C_CUR_FULL) begin
                            itime_d = buf_q;
                            ival_d  = 1'b1;
                            state_d = S_IDLE;
                            in_d    = 1'b0;
                            accept  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    4'ha, 4'hb: begin
                        accept = 1'b1;
                        // Repeated b on an empty alarm entry steps through the slots.
                        if (key_code == 4'hb && set_q && cur_q == '0) begin
                            slot_d = (slot_q == C_SLOT_MAX) ? '0 : slot_q + 1'b1;
                        end else begin
                            set_d  = (key_code == 4'hb);
                            slot_d = '0;
                            buf_d  = '0;
                            cur_d  = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TIME_ENTRY_BLINK_EN
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BCW-1:0] blink_cnt_q;
    logic           blink_on_q;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (accept || !in_q) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = accept & (BLINK_DIV > 0);
`endif

    // Scan groups of three: tens, ones, separator.
    always_comb begin
        int g, o, d;
        g    = int'(rr) / 3;
        o    = int'(rr) % 3;
        d    = 2 * g + o;
        dh_d = C_BLANK;
        if (in_q && o != 2 && d < DIGITS) begin
            if (d < int'(cur_q))
                dh_d = {1'b0, buf_q[4*(DIGITS-1-d) +: 4]};
`ifdef TIME_ENTRY_BLINK_EN
            else if (d == int'(cur_q) && blink_on_q)
                dh_d = 5'b01111;
`endif
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cur_q   <= '0;
            set_q   <= 1'b0;
            slot_q  <= '0;
            in_q    <= 1'b0;
            err_q   <= 1'b0;
            itime_q <= '0;
            ival_q  <= 1'b0;
            dh_q    <= C_BLANK;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cur_q   <= cur_d;
            set_q   <= set_d;
            slot_q  <= slot_d;
            in_q    <= in_d;
            err_q   <= err_d;
            itime_q <= itime_d;
            ival_q  <= ival_d;
            dh_q    <= dh_d;
        end
    end

    assign itime        = itime_q;
    assign itime_valid  = ival_q;
    assign set          = set_q;
    assign alarm_slot   = slot_q;
    assign in           = in_q;
    assign err          = err_q;
    assign digit_holder = dh_q;

endmodule
`default_nettype wire

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
- Keyboard-driven time/alarm entry controller, next generation of the single-format entry block.
- Takes decoded key codes as a synchronous strobe stream and builds an HH[:MM[:SS]] value digit by digit.
- Validates each digit against 24-hour limits and supports backspace, cancel and multiple alarm slots.
- Drives the seven-segment scan mux with the entry buffer and issues a one-cycle commit pulse to the clock/alarm registers.

Parameters:
- DIGITS, 6, BCD digits in the entry (2, 4 or 6; pairs are HH, MM, SS).
- ALARMS, 2, number of alarm slots (1..8).
- SCAN_W, 3, width of the display scan index.
- BLINK_DIV, 25000000, cursor blink half-period in clocks (used only with the optional feature).

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_code  in  4  decoded key: 0-9 digit, a clock-set, b alarm-set, c backspace, d cancel, e commit, f ignored.
- key_valid  in  1  one-cycle strobe, key_code valid; synchronous to CLK100MHZ.
- rr  in  SCAN_W  display scan position.
- itime  out  4*DIGITS  committed BCD time, most significant digit in the top nibble.
- itime_valid  out  1  one-cycle pulse when itime is updated.
- set  out  1  0 = commit targets the clock, 1 = commit targets an alarm.
- alarm_slot  out  clog2(ALARMS) (min 1)  target alarm index.
- in  out  1  entry mode active.
- err  out  1  one-cycle pulse on a rejected key.
- digit_holder  out  5  display digit; 5'b10000 = blank.

Behaviour:
- Reset (async, immediate):
  - itime=0, itime_valid=0, set=0, alarm_slot=0, in=0, err=0, digit_holder=5'b10000.
  - Internal: buffer=0, cursor=0, state=IDLE.
- States: IDLE, ENTRY. Key handling happens only on cycles with key_valid=1; all other cycles hold state.
- IDLE:
  - Key a: set=0, buffer cleared, cursor=0, in=1, go to ENTRY.
  - Key b: set=1, alarm_slot=0, buffer cleared, cursor=0, in=1, go to ENTRY.
  - All other keys: ignored, no err.
- ENTRY, digit key:
  - If cursor==DIGITS: err pulse, no change.
  - Else validate against digit position p=cursor:
    - p0 (H tens): 0-2.
    - p1 (H ones): 0-9, or 0-3 if buffered H tens==2.
    - p2 and p4 (tens): 0-5.
    - p3 and p5 (ones): 0-9.
  - Valid digit: buffer[p]=digit, cursor+1. Invalid digit: err pulse, no change.
- ENTRY, key c (backspace):
  - cursor>0: cursor-1, that digit cleared to 0.
  - cursor==0: err pulse.
- ENTRY, key d (cancel): in=0, go to IDLE. itime unchanged, no itime_valid.
- ENTRY, key e (commit):
  - cursor==DIGITS: itime<=buffer, itime_valid=1 for exactly the next cycle, in=0, go to IDLE.
  - Otherwise: err pulse, stay in ENTRY.
- ENTRY, key a or b:
  - Key b while set=1 and cursor==0: alarm_slot increments, wrapping ALARMS-1 -> 0.
  - All other cases: restart entry in the new mode, buffer cleared, cursor=0, alarm_slot=0.
- ENTRY, key f: ignored.
- Outputs err and itime_valid are registered and appear the cycle after the key strobe.
- set and alarm_slot hold their last values in IDLE.
- Display mapping:
  - rr is split into groups of 3 positions: [tens, ones, separator].
  - Position k=3g+o. For o<2, digit index d=2g+o.
  - digit_holder = {1'b0, buffer[d]} when in=1 and d<cursor.
  - Blank (5'b10000) when in=0, d>=cursor, o==2, or d>=DIGITS.
  - Registered: one-cycle latency from rr.
- Reset asserted mid-entry: entry is abandoned with no itime_valid, and all outputs go to their reset values.

Optional Feature:
- Macro: TIME_ENTRY_BLINK_EN.
- Defined:
  - A counter of clog2(BLINK_DIV) bits toggles a blink phase every BLINK_DIV clocks while in=1.
  - The counter is cleared and the phase is set to "on" on every accepted key.
  - While in=1 and cursor<DIGITS, the position d==cursor shows 5'b01111 (underscore glyph) in the "on" phase and blank in the "off" phase.
- Undefined: no counter; the cursor position shows blank, as do all other unentered digits.

Test Plan:
- reset, then a,1,2,3,4,5,6,e -> itime_valid pulses once; itime=24'h123456; set=0; in=0.
- b,b,b with ALARMS=2 -> alarm_slot 0->1->0. Then 0,7,3,0,0,0,e -> itime=24'h073000; set=1; alarm_slot=0.
- a,2,4 -> err pulse on the 4 and cursor stays 1. Then 3,6 -> err on the 6. Then c -> cursor=1 and buffer[1]=0.
- a,1,2,e -> err pulse, in stays 1, no itime_valid. Then d -> in=0 and itime unchanged.
- a,1,2 then sweep rr 0..7 -> digit_holder sequence 01,02,10,10,10,10,10,10 (hex), each one cycle after rr.
- a,1,2,3, reset pulse mid-entry -> in=0, itime=0, digit_holder=5'h10. A following e is ignored with no err.
